// File: rtl/subtrator_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the single-bit full-subtract function used by
// the datapath cell.
package subtrator_serial_pkg;

  // Default operand/result width in bits.
  localparam int unsigned SUB_DEFAULT_WIDTH = 8;

  // Control states of the serial subtractor.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } sub_state_t;

  // One-bit full subtract a - b - bin.
  // Returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
    logic diff;
    logic bout;
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~a & bin) | (b & bin);
    return {bout, diff};
  endfunction

endpackage

// File: rtl/subtrator_completo.sv
// Single-bit full-subtractor cell: d = a - b - bin, with borrow-out.
// Purely combinational; the serial wrapper registers the borrow.
module subtrator_completo
  import subtrator_serial_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic [1:0] res_s;

  // Evaluate the one-bit subtraction.
  always_comb begin
    res_s = full_sub(a, b, bin);
    d     = res_s[0];
    bout  = res_s[1];
  end

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor: D = A - B - BIN, one bit per clock, LSB first.
// Operands are captured on an accepted START and shifted through a single
// full-subtractor cell whose borrow is registered between bits. D/BOUT are
// loaded together in the cycle that completes the last bit, so they are
// already valid while DONE is high, and they hold until the next operation
// completes.
// Optional build macro: SUBTRATOR_SERIAL_OVF_EN adds the OVF output
// (signed two's-complement overflow of the last result).
module subtrator_serial
  import subtrator_serial_pkg::*;
#(
  parameter int unsigned N = SUB_DEFAULT_WIDTH
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         BIN,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] D,
`ifdef SUBTRATOR_SERIAL_OVF_EN
  output logic         BOUT,
  output logic         OVF
`else
  output logic         BOUT
`endif
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  sub_state_t  state_q, state_d;
  logic [N-1:0]  sa_q, sa_d;
  logic [N-1:0]  sb_q, sb_d;
  logic [N-1:0]  res_q, res_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  d_q, d_d;
  logic          bout_q, bout_d;
`ifdef SUBTRATOR_SERIAL_OVF_EN
  logic          a_msb_q, a_msb_d;
  logic          b_msb_q, b_msb_d;
  logic          ovf_q, ovf_d;
`endif

  logic          cell_d_s;
  logic          cell_bout_s;
  logic [N-1:0]  res_next_s;

  subtrator_completo u_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (br_q),
    .d    (cell_d_s),
    .bout (cell_bout_s)
  );

  // Result register after this bit: cell difference enters at the MSB.
  always_comb begin
    res_next_s = {cell_d_s, res_q[N-1:1]};
  end

  // Next-state, datapath and output-register computation.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    d_d     = d_q;
    bout_d  = bout_q;
`ifdef SUBTRATOR_SERIAL_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      // FINISH accepts a new request exactly like IDLE (back-to-back).
      ST_IDLE, ST_FINISH: begin
        if (START) begin
          sa_d    = A;
          sb_d    = B;
          br_d    = BIN;
          res_d   = {N{1'b0}};
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
`ifdef SUBTRATOR_SERIAL_OVF_EN
          a_msb_d = A[N-1];
          b_msb_d = B[N-1];
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sa_d  = {1'b0, sa_q[N-1:1]};
        sb_d  = {1'b0, sb_q[N-1:1]};
        br_d  = cell_bout_s;
        res_d = res_next_s;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the full result together with DONE.
          cnt_d   = {CW{1'b0}};
          state_d = ST_FINISH;
          done_d  = 1'b1;
          d_d     = res_next_s;
          bout_d  = cell_bout_s;
`ifdef SUBTRATOR_SERIAL_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (cell_d_s != a_msb_q);
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; async reset aborts any operation.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      sa_q    <= {N{1'b0}};
      sb_q    <= {N{1'b0}};
      res_q   <= {N{1'b0}};
      br_q    <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= {N{1'b0}};
      bout_q  <= 1'b0;
`ifdef SUBTRATOR_SERIAL_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
`ifdef SUBTRATOR_SERIAL_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Drive ports straight from registers.
  always_comb begin
    BUSY = busy_q;
    DONE = done_q;
    D    = d_q;
    BOUT = bout_q;
`ifdef SUBTRATOR_SERIAL_OVF_EN
    OVF  = ovf_q;
`endif
  end

endmodule

// File: tb/tb_subtrator_serial.sv
// Directed self-checking bench for subtrator_serial (N=8).
module tb_subtrator_serial;

  localparam int N = 8;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         BIN;
  logic         BUSY;
  logic         DONE;
  logic [N-1:0] D;
  logic         BOUT;
`ifdef SUBTRATOR_SERIAL_OVF_EN
  logic         OVF;
`endif

  int nvec = 0;
  int nerr = 0;

  subtrator_serial #(.N(N)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
    .BIN   (BIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .D     (D),
`ifdef SUBTRATOR_SERIAL_OVF_EN
    .BOUT  (BOUT),
    .OVF   (OVF)
`else
    .BOUT  (BOUT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    A     = a;
    B     = b;
    BIN   = bin;
    START = 1'b1;
  endtask

  // Follow one operation from its accepting edge to DONE (and one cycle past
  // unless START is held). glitch: cycle at which START is re-pulsed with
  // A=FF while busy (0 = none). pd: D value expected to hold until DONE.
  task automatic track(input string tag, input logic [N-1:0] ed, input logic eb,
                       input logic eo, input int glitch, input bit hold,
                       input logic [N-1:0] pd);
    @(posedge CLK); #1;
    if (!hold) START = 1'b0;
    chk({tag, ":busy0"}, {31'd0, BUSY}, 32'd1);
    chk({tag, ":done0"}, {31'd0, DONE}, 32'd0);
    chk({tag, ":dhold0"}, {24'd0, D}, {24'd0, pd});
    for (int i = 1; i <= N; i++) begin
      if (i == glitch) begin
        START = 1'b1;
        A     = 8'hFF;
        B     = 8'h00;
      end else if (!hold) begin
        START = 1'b0;
      end
      @(posedge CLK); #1;
      if (i < N) begin
        chk({tag, ":busy"}, {30'd0, BUSY, DONE}, {30'd0, 1'b1, 1'b0});
        chk({tag, ":dhold"}, {24'd0, D}, {24'd0, pd});
      end else begin
        chk({tag, ":fin_busy_done"}, {30'd0, BUSY, DONE}, {30'd0, 1'b0, 1'b1});
        chk({tag, ":d"}, {24'd0, D}, {24'd0, ed});
        chk({tag, ":bout"}, {31'd0, BOUT}, {31'd0, eb});
`ifdef SUBTRATOR_SERIAL_OVF_EN
        chk({tag, ":ovf"}, {31'd0, OVF}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("unexpected x");
`endif
      end
    end
    if (!hold) begin
      @(posedge CLK); #1;
      chk({tag, ":post_busy_done"}, {30'd0, BUSY, DONE}, 32'd0);
      chk({tag, ":post_d"}, {23'd0, BOUT, D}, {23'd0, eb, ed});
    end
  endtask

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    A     = 8'h00;
    B     = 8'h00;
    BIN   = 1'b0;
    #22;
    chk("reset", {21'd0, BUSY, DONE, BOUT, D}, 32'd0);
`ifdef SUBTRATOR_SERIAL_OVF_EN
    chk("reset_ovf", {31'd0, OVF}, 32'd0);
`endif
    RST_N = 1'b1;
    @(posedge CLK); #1;

    launch(8'h05, 8'h03, 1'b0);
    track("5m3", 8'h02, 1'b0, 1'b0, 0, 1'b0, 8'h00);

    launch(8'h03, 8'h05, 1'b0);
    track("3m5", 8'hFE, 1'b1, 1'b0, 0, 1'b0, 8'h02);

    launch(8'h00, 8'h00, 1'b1);
    track("0m0b", 8'hFF, 1'b1, 1'b0, 0, 1'b0, 8'hFE);

    launch(8'h80, 8'h01, 1'b0);
    track("80m1", 8'h7F, 1'b0, 1'b1, 0, 1'b0, 8'hFF);

    // START re-pulsed at cycle 3 while busy must be ignored.
    launch(8'h10, 8'h01, 1'b0);
    track("ignore", 8'h0F, 1'b0, 1'b0, 3, 1'b0, 8'h7F);

    // START held across FINISH: second operation accepted back-to-back.
    launch(8'h20, 8'h03, 1'b0);
    track("b2b1", 8'h1D, 1'b0, 1'b0, 0, 1'b1, 8'h0F);
    A = 8'h7F;
    B = 8'hFF;
    BIN = 1'b0;
    track("b2b2", 8'h80, 1'b1, 1'b1, 0, 1'b0, 8'h1D);

    // Reset in the middle of an operation.
    launch(8'h05, 8'h03, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      START = 1'b0;
    end
    RST_N = 1'b0;
    #1;
    chk("abort", {21'd0, BUSY, DONE, BOUT, D}, 32'd0);
`ifdef SUBTRATOR_SERIAL_OVF_EN
    chk("abort_ovf", {31'd0, OVF}, 32'd0);
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < N + 3; i++) begin
      @(posedge CLK); #1;
      chk("no_done_after_abort", {30'd0, BUSY, DONE}, 32'd0);
    end

    launch(8'h05, 8'h03, 1'b1);
    track("after_rst", 8'h01, 1'b0, 1'b0, 0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
